// File: rtl/carry_save_accumulator_ctrl_pkg.sv
// Shared definitions for the carry-save accumulator: FSM state encodings and
// width derivations used by the top-level parameter list.
package carry_save_accumulator_ctrl_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCUM   = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // Wide enough for max_ops * (2^width - 1), so the running sum never overflows.
  function automatic int acc_width(input int width, input int max_ops);
    return width + $clog2(max_ops);
  endfunction

  function automatic int cnt_width(input int max_ops);
    return $clog2(max_ops + 1);
  endfunction

endpackage

// File: rtl/carry_save_accumulator_ctrl_csa.sv
// Parametric-width 3:2 carry-save stage built from a row of independent full adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module carry_save_logic_n #(
  parameter int N = 7
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] cin,
  output logic [N-1:0] sum,
  output logic [N-1:0] cout
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (cin[i]),
      .sum (sum[i]),
      .cout(cout[i])
    );
  end
endmodule

// File: rtl/carry_save_accumulator_ctrl.sv
// Multi-operand adder front end: absorbs one operand per handshake into a redundant
// (sum, carry) pair and resolves it with a single carry-propagate add at the end.
module carry_save_accumulator_ctrl
  import carry_save_accumulator_ctrl_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int MAX_OPS = 8,
  localparam int CNT_W   = cnt_width(MAX_OPS),
  localparam int ACC_W   = acc_width(WIDTH, MAX_OPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] op_count,
  output logic             busy,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0]       state;
  logic [ACC_W-1:0] sum_r;
  logic [ACC_W-1:0] carry_r;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] in_ext;
  logic [ACC_W-1:0] csa_s;
  logic [ACC_W-1:0] csa_c;
  logic [CNT_W-1:0] cnt_load;
  logic             fire;

  assign in_ext   = ACC_W'(in_data);
  assign cnt_load = (op_count > CNT_W'(MAX_OPS)) ? CNT_W'(MAX_OPS) : op_count;
  assign busy     = (state != IDLE);
  assign in_ready = (state == ACCUM);
  assign fire     = in_valid && in_ready;

  carry_save_logic_n #(.N(ACC_W)) u_csa (
    .a   (sum_r),
    .b   (carry_r),
    .cin (in_ext),
    .sum (csa_s),
    .cout(csa_c)
  );

  // NOTE: every register here is a handful of flops, so all of them take the async
  // reset; a mid-job reset must leave no trace of the aborted accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sum_r     <= '0;
      carry_r   <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum_r   <= '0;
            carry_r <= '0;
            cnt     <= cnt_load;
            state   <= (op_count == '0) ? RESOLVE : ACCUM;
          end
        end
        ACCUM: begin
          if (fire) begin
            sum_r   <= csa_s;
            // The carry bit shifted out of the MSB is always zero given ACC_W.
            carry_r <= csa_c << 1;
            cnt     <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_data  <= sum_r + carry_r;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
